bcd_display_scan: RTL and testbench

- Downstream consumer of the alarm-clock core (`Aclock`).
- Takes its six BCD time digits (HH:MM:SS), the Alarm output and the AL_ON enable, and drives a 6-digit multiplexed common-anode 7-segment display.
- Snapshots all digits once per scan frame so that a single frame never mixes two different times.
- Blanks the whole display in a periodic blink while the alarm is sounding.

---
 rtl/bcd_display_scan.sv | 182 ++++++++++++++++++
 tb/tb_bcd_display_scan.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// bcd_display_scan
//   Scans six BCD time digits (HH:MM:SS) from the alarm-clock core onto a
//   6-digit multiplexed common-anode 7-segment display. All digits and AL_ON
//   are snapshotted once per scan frame, so a frame never mixes two times.
//   While Alarm is high the whole display blinks, BLINK_FRAMES frames per
//   half-period.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   H_in1..S_in0          BCD time digits (H_in1 is 2 bits wide)
//   Alarm                 alarm sounding (level), drives blinking
//   AL_ON                 alarm armed (level), lights dp on the rightmost digit
//   an[5:0]               digit anodes, active-low, an[0] = rightmost digit
//   seg[6:0]              segments {g,f,e,d,c,b,a}, active-low
//   dp                    decimal point, active-low
//
// Parameters
//   SCAN_DIV      clock cycles per digit (>= 2)
//   BLINK_FRAMES  frames per blink half-period (>= 1)
//   LZB           1 = blank the tens-of-hours digit when it is 0
module bcd_display_scan #(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 2,
  parameter int LZB          = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] H_in1,
  input  logic [3:0] H_in0,
  input  logic [3:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic [3:0] S_in1,
  input  logic [3:0] S_in0,
  input  logic       Alarm,
  input  logic       AL_ON,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [FW-1:0] FC_MAX  = FW'(BLINK_FRAMES - 1);
  localparam logic [FW-1:0] FC_ONE  = FW'(1);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [FW-1:0] r_frame_cnt;
  logic          r_blink_phase;
  logic [3:0]    r_snap_s0, r_snap_s1, r_snap_m0, r_snap_m1, r_snap_h0, r_snap_h1;
  logic          r_snap_al_on;
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_frame_start;
  logic [3:0]    w_digit;
  logic          w_al_on;
  logic          w_blink_nxt;
  logic [FW-1:0] w_frame_cnt_nxt;
  logic [6:0]    w_seg;
  logic          w_dp;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h3F;  // non-BCD: dash
    endcase
  endfunction

  assign w_frame_start = (r_cnt == '0) && (r_idx == 3'd0);

  // A frame always starts on idx0, so only that digit (and AL_ON, which only
  // affects idx0) needs the live-input bypass to show the new snapshot.
  always_comb begin
    w_digit = 4'd0;
    case (r_idx)
      3'd0:    w_digit = w_frame_start ? S_in0 : r_snap_s0;
      3'd1:    w_digit = r_snap_s1;
      3'd2:    w_digit = r_snap_m0;
      3'd3:    w_digit = r_snap_m1;
      3'd4:    w_digit = r_snap_h0;
      3'd5:    w_digit = r_snap_h1;
      default: w_digit = 4'd0;
    endcase
  end

  assign w_al_on = w_frame_start ? AL_ON : r_snap_al_on;

  // Blanking follows the phase being loaded on this edge, so frame
  // boundaries line up with blink boundaries and dropping Alarm un-blanks
  // the very next output cycle.
  always_comb begin
    w_blink_nxt     = r_blink_phase;
    w_frame_cnt_nxt = r_frame_cnt;
    if (!Alarm) begin
      w_blink_nxt     = 1'b0;
      w_frame_cnt_nxt = '0;
    end else if (w_frame_start) begin
      if (r_frame_cnt == FC_MAX) begin
        w_blink_nxt     = ~r_blink_phase;
        w_frame_cnt_nxt = '0;
      end else begin
        w_frame_cnt_nxt = r_frame_cnt + FC_ONE;
      end
    end
  end

  always_comb begin
    w_seg = seg7(w_digit);
    w_dp  = 1'b1;
    if ((LZB != 0) && (r_idx == 3'd5) && (w_digit == 4'd0)) begin
      w_seg = 7'h7F;
    end
    if ((r_idx == 3'd2) || (r_idx == 3'd4) || ((r_idx == 3'd0) && w_al_on)) begin
      w_dp = 1'b0;
    end
    if (w_blink_nxt) begin
      w_seg = 7'h7F;
      w_dp  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_idx         <= 3'd0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_snap_s0     <= 4'd0;
      r_snap_s1     <= 4'd0;
      r_snap_m0     <= 4'd0;
      r_snap_m1     <= 4'd0;
      r_snap_h0     <= 4'd0;
      r_snap_h1     <= 4'd0;
      r_snap_al_on  <= 1'b0;
      r_an          <= 6'h3F;
      r_seg         <= 7'h7F;
      r_dp          <= 1'b1;
    end else begin
      if (r_cnt == CNT_MAX) begin
        r_cnt <= '0;
        r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end

      if (w_frame_start) begin
        r_snap_s0    <= S_in0;
        r_snap_s1    <= S_in1;
        r_snap_m0    <= M_in0;
        r_snap_m1    <= M_in1;
        r_snap_h0    <= H_in0;
        r_snap_h1    <= {2'b00, H_in1};
        r_snap_al_on <= AL_ON;
      end

      r_frame_cnt   <= w_frame_cnt_nxt;
      r_blink_phase <= w_blink_nxt;

      r_an  <= ~(6'b000001 << r_idx);
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Testbench for bcd_display_scan: directed stimulus, a frame-level reference
// model checked every cycle, and literal expectations at key points.
module tb_bcd_display_scan;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME = 6 * SD;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0, S_in1, S_in0;
  logic       Alarm, AL_ON;
  logic [5:0] an, an_n;
  logic [6:0] seg, seg_n;
  logic       dp, dp_n;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  bcd_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZB(1)) dut (
    .clk(clk), .reset(reset),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .S_in1(S_in1), .S_in0(S_in0), .Alarm(Alarm), .AL_ON(AL_ON),
    .an(an), .seg(seg), .dp(dp)
  );

  bcd_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZB(0)) dut_nolzb (
    .clk(clk), .reset(reset),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .S_in1(S_in1), .S_in0(S_in0), .Alarm(Alarm), .AL_ON(AL_ON),
    .an(an_n), .seg(seg_n), .dp(dp_n)
  );

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  int         m_t;
  int         m_nal;
  int         m_idx;
  bit         m_valid = 1'b0;
  logic [3:0] m_snap [6];
  logic       m_al_on;
  logic       m_blank;
  logic [3:0] m_d;
  logic [5:0] m_an;
  logic [6:0] m_seg, m_seg_n;
  logic       m_dp;

  // t counts non-reset edges since reset; the digit shown after an edge is
  // (t / SD) % 6 and a new frame starts every FRAME edges. Blink phase is the
  // parity of (frame starts seen with Alarm high) / BF.
  always @(posedge clk) begin
    if (reset) begin
      m_t     = 0;
      m_nal   = 0;
      m_an    = 6'h3F;
      m_seg   = 7'h7F;
      m_seg_n = 7'h7F;
      m_dp    = 1'b1;
      for (int k = 0; k < 6; k++) m_snap[k] = 4'd0;
      m_al_on = 1'b0;
    end else begin
      m_idx = (m_t / SD) % 6;
      if (m_t % FRAME == 0) begin
        m_snap[0] = S_in0;
        m_snap[1] = S_in1;
        m_snap[2] = M_in0;
        m_snap[3] = M_in1;
        m_snap[4] = H_in0;
        m_snap[5] = {2'b00, H_in1};
        m_al_on   = AL_ON;
        if (Alarm) m_nal = m_nal + 1;
      end
      if (!Alarm) m_nal = 0;
      m_blank = Alarm && (((m_nal / BF) % 2) == 1);
      m_an = 6'h3F;
      m_an[m_idx] = 1'b0;
      m_d = m_snap[m_idx];
      if (m_blank) begin
        m_seg   = 7'h7F;
        m_seg_n = 7'h7F;
        m_dp    = 1'b1;
      end else begin
        m_seg_n = seg_tab[m_d];
        m_seg   = (m_idx == 5 && m_d == 4'd0) ? 7'h7F : seg_tab[m_d];
        m_dp    = (m_idx == 2 || m_idx == 4 || (m_idx == 0 && m_al_on)) ? 1'b0 : 1'b1;
      end
      m_t = m_t + 1;
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_asserts++;
      if (an !== m_an || seg !== m_seg || dp !== m_dp) begin
        n_fail++;
        $display("FAIL model_lzb1 @%0t: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                 $time, an, seg, dp, m_an, m_seg, m_dp);
      end
      n_asserts++;
      if (an_n !== m_an || seg_n !== m_seg_n || dp_n !== m_dp) begin
        n_fail++;
        $display("FAIL model_lzb0 @%0t: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                 $time, an_n, seg_n, dp_n, m_an, m_seg_n, m_dp);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input bit use_nolzb,
                     input logic [5:0] ea, input logic [6:0] es, input logic ed);
    logic [5:0] a;
    logic [6:0] s;
    logic       d;
    a = use_nolzb ? an_n  : an;
    s = use_nolzb ? seg_n : seg;
    d = use_nolzb ? dp_n  : dp;
    n_asserts++;
    if (a !== ea || s !== es || d !== ed) begin
      n_fail++;
      $display("FAIL %s: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
               name, a, s, d, ea, es, ed);
    end
  endtask

  logic [5:0] an_seq  [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
  logic [6:0] seg_seq [6] = '{7'h12, 7'h40, 7'h10, 7'h79, 7'h40, 7'h79};

  initial begin
    reset = 1'b1;
    H_in1 = 2'd1; H_in0 = 4'd0;
    M_in1 = 4'd1; M_in0 = 4'd9;
    S_in1 = 4'd0; S_in0 = 4'd5;
    Alarm = 1'b0; AL_ON = 1'b0;

    // 1: reset held 3 cycles, then one frame of 10:19:05
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("reset_dark", 1'b0, 6'h3F, 7'h7F, 1'b1);
    end
    reset = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      tick(1);
      chk("first_frame", 1'b0, an_seq[i/SD], seg_seq[i/SD],
          ((i/SD) == 2 || (i/SD) == 4) ? 1'b0 : 1'b1);
    end

    // 2: M_in0 changes mid-frame; snapshot holds until the next frame
    tick(10);
    M_in0 = 4'd3;
    tick(1);
    chk("snap_hold_10", 1'b0, 6'h3B, 7'h10, 1'b0);
    tick(1);
    chk("snap_hold_11", 1'b0, 6'h3B, 7'h10, 1'b0);
    tick(FRAME - 12);
    tick(9);
    chk("snap_new", 1'b0, 6'h3B, 7'h30, 1'b0);
    tick(FRAME - 9);

    // 3: leading-zero blanking on tens of hours
    H_in1 = 2'd0; H_in0 = 4'd7;
    for (int i = 0; i < FRAME; i++) begin
      tick(1);
      if (i == 16) chk("h0_seven", 1'b0, 6'h2F, 7'h78, 1'b0);
      if (i == 20) begin
        chk("lzb_blank", 1'b0, 6'h1F, 7'h7F, 1'b1);
        chk("lzb_off_zero", 1'b1, 6'h1F, 7'h40, 1'b1);
      end
    end

    // 4: illegal BCD shows a dash
    S_in0 = 4'hB;
    for (int i = 0; i < FRAME; i++) begin
      tick(1);
      if (i == 0) chk("dash", 1'b0, 6'h3E, 7'h3F, 1'b1);
      if (i == 4) chk("dash_neighbor", 1'b0, 6'h3D, 7'h40, 1'b1);
    end
    S_in0 = 4'd5;

    // 5: alarm blink, Alarm raised just after a frame start
    AL_ON = 1'b1;
    tick(1);
    chk("al_f0", 1'b0, 6'h3E, 7'h12, 1'b0);
    Alarm = 1'b1;
    tick(FRAME - 1);
    for (int f = 1; f < 6; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        tick(1);
        if (f == 1 && i == 0)  chk("al_f1", 1'b0, 6'h3E, 7'h12, 1'b0);
        if (f == 2 && i == 0)  chk("al_f2_blank", 1'b0, 6'h3E, 7'h7F, 1'b1);
        if (f == 2 && i == 12) chk("al_f2_scan", 1'b0, 6'h37, 7'h7F, 1'b1);
        if (f == 3 && i == 4)  chk("al_f3_blank", 1'b0, 6'h3D, 7'h7F, 1'b1);
        if (f == 4 && i == 0)  chk("al_f4", 1'b0, 6'h3E, 7'h12, 1'b0);
        if (f == 5 && i == 8)  chk("al_f5", 1'b0, 6'h3B, 7'h30, 1'b0);
      end
    end
    tick(5);
    chk("al_f6_blank", 1'b0, 6'h3D, 7'h7F, 1'b1);
    Alarm = 1'b0;
    tick(1);
    chk("al_drop", 1'b0, 6'h3D, 7'h40, 1'b1);
    tick(FRAME - 6);

    // 6: one-cycle reset in the middle of idx3
    tick(3 * SD + 1);
    reset = 1'b1;
    tick(1);
    chk("mid_reset", 1'b0, 6'h3F, 7'h7F, 1'b1);
    reset = 1'b0;
    tick(1);
    chk("restart", 1'b0, 6'h3E, 7'h12, 1'b0);
    tick(FRAME - 1);
    tick(FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
